// File: rtl/kf_axi_pkg.sv
// Shared AXI encodings and burst helpers for the memory responder slice.
package kf_axi_pkg;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_64B    = 3'b110;

  typedef struct packed {
    logic [7:0] len;
    logic [1:0] burst;
    logic       err;
  } axi_burst_ctx_t;

  // Only full-width FIXED/INCR bursts are served; everything else is SLVERR.
  function automatic logic axi_burst_unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_SIZE_64B) || !(burst == AXI_BURST_FIXED || burst == AXI_BURST_INCR);
  endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat index for a burst: INCR steps by one (wrapping at DEPTH), others hold.
module axi_burst_addr_gen
  import kf_axi_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       burst,
  output logic [IDX_W-1:0] next_idx
);
  always_comb begin
    next_idx = idx;
    if (burst == AXI_BURST_INCR) next_idx = IDX_W'(idx + 1'b1);
  end
endmodule

// File: rtl/axi_burst_mem_responder.sv
// AXI4 burst slave over a DEPTH x 512-bit memory; independent read and write FSMs.
module axi_burst_mem_responder
  import kf_axi_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [31:0]           s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [AXI_DATA_W-1:0] s_axi_wdata,
  input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic                  s_axi_wlast,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  // Low 6 bits and bits above the index are address bits this memory ignores.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr, s_axi_awaddr};

  // ---------------- read channel ----------------
  r_state_t       r_state, r_next;
  axi_burst_ctx_t r_ctx;
  logic [IDX_W-1:0] r_idx, r_idx_nxt, ar_idx;
  logic [7:0]     r_cnt;
  logic           ar_hs, r_hs, ar_err;

  assign ar_idx        = s_axi_araddr[6 +: IDX_W];
  assign ar_err        = axi_burst_unsupported(s_axi_arsize, s_axi_arburst);
  assign s_axi_arready = (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_BURST);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign r_hs          = s_axi_rvalid && s_axi_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_axi_arvalid) r_next = R_BURST;
      R_BURST: if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
    endcase
  end

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rd_gen (
    .idx(r_idx), .burst(r_ctx.burst), .next_idx(r_idx_nxt)
  );

  // rdata is registered from the array, so a same-cycle write lands after the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctx       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= AXI_RESP_OKAY;
      s_axi_rlast <= 1'b0;
    end else if (ar_hs) begin
      r_ctx       <= '{len: s_axi_arlen, burst: s_axi_arburst, err: ar_err};
      r_idx       <= ar_idx;
      r_cnt       <= '0;
      s_axi_rdata <= ar_err ? '0 : mem[ar_idx];
      s_axi_rresp <= ar_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      s_axi_rlast <= (s_axi_arlen == 8'd0);
    end else if (r_hs && !s_axi_rlast) begin
      r_idx       <= r_idx_nxt;
      r_cnt       <= r_cnt + 8'd1;
      s_axi_rdata <= r_ctx.err ? '0 : mem[r_idx_nxt];
      s_axi_rlast <= (r_cnt + 8'd1 == r_ctx.len);
    end else if (r_hs) begin
      s_axi_rlast <= 1'b0;
    end
  end

  // ---------------- write channel ----------------
  w_state_t       w_state, w_next;
  axi_burst_ctx_t w_ctx;
  logic [IDX_W-1:0] w_idx, w_idx_nxt;
  logic [8:0]     w_cnt;
  logic           aw_hs, w_hs, w_commit;

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign w_commit      = w_hs && !rst && !w_ctx.err && (w_cnt <= {1'b0, w_ctx.len});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s_axi_awvalid) w_next = W_DATA;
      W_DATA:  if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wr_gen (
    .idx(w_idx), .burst(w_ctx.burst), .next_idx(w_idx_nxt)
  );

  // w_cnt saturates so a runaway burst can never alias back to a legal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ctx       <= '0;
      w_idx       <= '0;
      w_cnt       <= '0;
      s_axi_bresp <= AXI_RESP_OKAY;
    end else if (aw_hs) begin
      w_ctx <= '{len: s_axi_awlen, burst: s_axi_awburst,
                 err: axi_burst_unsupported(s_axi_awsize, s_axi_awburst)};
      w_idx <= s_axi_awaddr[6 +: IDX_W];
      w_cnt <= '0;
    end else if (w_hs) begin
      w_idx <= w_idx_nxt;
      if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
      if (s_axi_wlast)
        s_axi_bresp <= (w_ctx.err || w_cnt != {1'b0, w_ctx.len}) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end
  end

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (w_commit)
      for (int b = 0; b < AXI_STRB_W; b++)
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  end
endmodule
